// File: rtl/clock_pkg.sv
// ==========================================================================
// clock_pkg: shared types and constants for the alarm-clock keypad entry path.
// Rev 1.0
// ==========================================================================
`default_nettype none

package clock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 4;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);
  localparam int MAX_HOUR   = 12;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENTRY      = 3'd1,
    STORED     = 3'd2,
    LOAD_TIME  = 3'd3,
    LOAD_ALARM = 3'd4
  } tsc_state_t;

  // Minutes units digit is always 0..9 because the keypad filter drops 10..15.
  function automatic logic is_valid_12h(input logic [DIGIT_W-1:0] ms_hr,
                                        input logic [DIGIT_W-1:0] ls_hr,
                                        input logic [DIGIT_W-1:0] ms_min);
    logic [7:0] hour;
    hour = 8'(ms_hr) * 8'd10 + 8'(ls_hr);
    return (ms_hr <= 4'd1) && (hour >= 8'd1) && (hour <= 8'(MAX_HOUR)) &&
           (ms_min <= 4'd5);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_shift_buffer.sv
// ==========================================================================
// key_shift_buffer: four-digit BCD shift register with clear and digit count.
// Rev 1.0
// ==========================================================================
`default_nettype none

module key_shift_buffer
  import clock_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [DIGIT_W-1:0] key,
  output logic [DIGIT_W-1:0] digit3,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit0,
  output logic [CNT_W-1:0]   count
);

  logic [MAX_DIGITS-1:0][DIGIT_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]                   count_q, count_d;

  // Clear is applied before the shift so clr+shift_en yields {0,0,0,key}.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (clr) begin
      buf_d   = '0;
      count_d = '0;
    end
    if (shift_en) begin
      buf_d = {buf_d[MAX_DIGITS-2:0], key};
      if (count_d < CNT_W'(MAX_DIGITS)) begin
        count_d = count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign digit3 = buf_q[3];
  assign digit2 = buf_q[2];
  assign digit1 = buf_q[1];
  assign digit0 = buf_q[0];
  assign count  = count_q;

endmodule

`default_nettype wire

// File: rtl/time_set_controller.sv
// ==========================================================================
// time_set_controller: keypad time/alarm entry sequencer with idle timeout.
// Optional commit-time 12-hour validation under TIME_SET_VALIDATE_EN.  Rev 1.0
// ==========================================================================
`default_nettype none

module time_set_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         one_second,
  input  logic [3:0]   key,
  input  logic         key_valid,
  input  logic         time_button,
  input  logic         alarm_button,
  input  logic         am_sel,
  output logic [3:0]   key_buffer_ms_hr,
  output logic [3:0]   key_buffer_ls_hr,
  output logic [3:0]   key_buffer_ms_min,
  output logic [3:0]   key_buffer_ls_min,
  output logic         key_buffer_AM,
  output logic         load_new_c,
  output logic         load_new_a,
  output logic         show_new_time,
  output logic         entry_error
);

  localparam logic [8:0] c_timeout = 9'(TIMEOUT_SECS);

  tsc_state_t       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             am_q, am_d;
  logic             buf_clr, buf_shift;
  logic [CNT_W-1:0] digit_count;
  logic             key_ok;
  logic             button;
  logic             commit_ok;
  logic [8:0]       timer_inc;

  assign key_ok    = key_valid && (key <= 4'd9);
  assign button    = time_button | alarm_button;
  assign timer_inc = {1'b0, timer_q} + 9'd1;

`ifdef TIME_SET_VALIDATE_EN
  logic err_q, err_d;
  assign commit_ok = is_valid_12h(key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min);
`else
  assign commit_ok = 1'b1;
`endif

  // Priority inside an entry: button, then key, then timebase tick.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    am_d      = am_q;
    buf_clr   = 1'b0;
    buf_shift = 1'b0;
`ifdef TIME_SET_VALIDATE_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (key_ok) begin
          buf_clr   = 1'b1;
          buf_shift = 1'b1;
          timer_d   = '0;
          state_d   = ENTRY;
        end
      end
      ENTRY, STORED: begin
        if (button) begin
          timer_d = '0;
          if (commit_ok) begin
            am_d    = am_sel;
            state_d = time_button ? LOAD_TIME : LOAD_ALARM;
          end else begin
`ifdef TIME_SET_VALIDATE_EN
            err_d   = 1'b1;
`endif
            buf_clr = 1'b1;
            state_d = IDLE;
          end
        end else if (key_ok) begin
          // A full buffer ignores the digit but still counts it as activity.
          timer_d = '0;
          if (state_q == ENTRY) begin
            buf_shift = 1'b1;
            if (digit_count == CNT_W'(MAX_DIGITS - 1)) begin
              state_d = STORED;
            end
          end
        end else if (one_second) begin
          if (timer_inc == c_timeout) begin
            timer_d = '0;
            buf_clr = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_inc[7:0];
          end
        end
      end
      LOAD_TIME, LOAD_ALARM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      am_q    <= 1'b0;
`ifdef TIME_SET_VALIDATE_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      am_q    <= am_d;
`ifdef TIME_SET_VALIDATE_EN
      err_q   <= err_d;
`endif
    end
  end

  key_shift_buffer u_key_shift_buffer (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .shift_en (buf_shift),
    .key      (key),
    .digit3   (key_buffer_ms_hr),
    .digit2   (key_buffer_ls_hr),
    .digit1   (key_buffer_ms_min),
    .digit0   (key_buffer_ls_min),
    .count    (digit_count)
  );

  assign key_buffer_AM = am_q;
  assign load_new_c    = (state_q == LOAD_TIME);
  assign load_new_a    = (state_q == LOAD_ALARM);
  assign show_new_time = (state_q == ENTRY) || (state_q == STORED);

`ifdef TIME_SET_VALIDATE_EN
  assign entry_error = err_q;
`else
  assign entry_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_set_controller.sv
// ==========================================================================
// tb_time_set_controller: directed scoreboard bench for time_set_controller.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_time_set_controller;

  localparam int TO = 10;

`ifdef TIME_SET_VALIDATE_EN
  localparam bit VALIDATE = 1'b1;
`else
  localparam bit VALIDATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       one_second;
  logic [3:0] key;
  logic       key_valid;
  logic       time_button;
  logic       alarm_button;
  logic       am_sel;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       am_out, lc, la, show, err;

  time_set_controller #(.TIMEOUT_SECS(TO)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .one_second        (one_second),
    .key               (key),
    .key_valid         (key_valid),
    .time_button       (time_button),
    .alarm_button      (alarm_button),
    .am_sel            (am_sel),
    .key_buffer_ms_hr  (ms_hr),
    .key_buffer_ls_hr  (ls_hr),
    .key_buffer_ms_min (ms_min),
    .key_buffer_ls_min (ls_min),
    .key_buffer_AM     (am_out),
    .load_new_c        (lc),
    .load_new_a        (la),
    .show_new_time     (show),
    .entry_error       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;   // {load_new_c, load_new_a, entry_error}
    logic [15:0] digits;
    logic        am;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  wire [15:0] buf_now = {ms_hr, ls_hr, ms_min, ls_min};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected legality of a commit given digits {ms_hr, ls_hr, ms_min}.
  function automatic bit commit_ok(input logic [11:0] hi);
    int hour;
    bit valid;
    hour  = int'(hi[11:8]) * 10 + int'(hi[7:4]);
    valid = (hi[11:8] <= 4'd1) && (hour >= 1) && (hour <= 12) && (hi[3:0] <= 4'd5);
    return valid || !VALIDATE;
  endfunction

  function automatic exp_t make_exp(input bit is_time, input logic [15:0] digits, input logic am);
    exp_t e;
    if (commit_ok(digits[15:4])) begin
      e.kind   = is_time ? 3'b100 : 3'b010;
      e.digits = digits;
    end else begin
      e.kind   = 3'b001;
      e.digits = 16'h0000;
    end
    e.am = am;
    return e;
  endfunction

  task automatic step(input logic kv, input logic [3:0] k, input logic tbtn,
                      input logic abtn, input logic os);
    @(negedge clk);
    key_valid    = kv;
    key          = k;
    time_button  = tbtn;
    alarm_button = abtn;
    one_second   = os;
    @(posedge clk);
    #1;
    key_valid    = 1'b0;
    time_button  = 1'b0;
    alarm_button = 1'b0;
    one_second   = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic commit(input bit is_time, input logic am, input logic [15:0] digits);
    am_sel = am;
    sb.push_back(make_exp(is_time, digits, am));
    step(1'b0, 4'd0, is_time, !is_time, 1'b0);
  endtask

  // Every strobe cycle must match exactly one pending expectation.
  always @(negedge clk) begin
    if (rst_n && (lc || la || err)) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_strobe observed=%b expected=none", {lc, la, err});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("strobe_kind", {29'd0, lc, la, err}, {29'd0, e.kind});
        chk("strobe_digits", {16'd0, buf_now}, {16'd0, e.digits});
        if (e.kind != 3'b001) chk("strobe_am", {31'd0, am_out}, {31'd0, e.am});
      end
    end
  end

  initial begin
    rst_n = 1'b0; one_second = 1'b0; key = 4'd0; key_valid = 1'b0;
    time_button = 1'b0; alarm_button = 1'b0; am_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {11'd0, show, lc, la, err, am_out, buf_now}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Buttons with nothing entered do nothing.
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("idle_button_show", {31'd0, show}, 32'd0);

    // Full entry committed as current time, AM set.
    am_sel = 1'b1;
    press(4'd1);
    chk("first_key_buf", {16'd0, buf_now}, 32'h0001);
    chk("first_key_show", {31'd0, show}, 32'd1);
    press(4'd2); press(4'd5); press(4'd8);
    chk("four_key_buf", {16'd0, buf_now}, 32'h1258);
    chk("four_key_show", {31'd0, show}, 32'd1);
    commit(1'b1, 1'b1, 16'h1258);
    chk("load_show_low", {31'd0, show}, 32'd0);
    idle();
    chk("after_load", {30'd0, show, lc}, 32'd0);

    // Partial entry committed as alarm.
    press(4'd7); press(4'd3);
    chk("partial_buf", {16'd0, buf_now}, 32'h0073);
    commit(1'b0, 1'b0, 16'h0073);
    idle();
    chk("after_alarm", {30'd0, show, la}, 32'd0);

    // Fifth digit ignored.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd9);
    chk("fifth_key_ignored", {16'd0, buf_now}, 32'h1234);
    commit(1'b1, 1'b0, 16'h1234);
    idle();

    // Timeout abandons the entry.
    press(4'd4);
    repeat (TO - 1) tick();
    chk("pre_timeout_show", {31'd0, show}, 32'd1);
    tick();
    chk("timeout_state", {15'd0, show, buf_now}, 32'd0);
    idle();

    // Invalid key does not restart the timer.
    press(4'd4);
    repeat (5) tick();
    press(4'd15);
    chk("bad_key_buf", {16'd0, buf_now}, 32'h0004);
    repeat (TO - 6) tick();
    chk("bad_key_pre_timeout", {31'd0, show}, 32'd1);
    tick();
    chk("bad_key_timeout", {15'd0, show, buf_now}, 32'd0);

    // A key in STORED is dropped but restarts the timer.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    repeat (TO - 1) tick();
    press(4'd5);
    repeat (TO - 1) tick();
    chk("stored_restart", {15'd0, show, buf_now}, {15'd0, 1'b1, 16'h1234});
    tick();
    chk("stored_timeout", {31'd0, show}, 32'd0);

    // Both buttons plus a key in one cycle: time wins, key dropped.
    press(4'd1);
    am_sel = 1'b1;
    sb.push_back(make_exp(1'b1, 16'h0001, 1'b1));
    step(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
    idle();
    chk("simul_done_show", {31'd0, show}, 32'd0);

    // Button in the same cycle as the timing-out tick: button wins.
    press(4'd1); press(4'd0); press(4'd3); press(4'd0);
    repeat (TO - 1) tick();
    am_sel = 1'b0;
    sb.push_back(make_exp(1'b1, 16'h1030, 1'b0));
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    idle();

    // Hour 13 vs 09:59.
    press(4'd1); press(4'd3); press(4'd0); press(4'd0);
    commit(1'b1, 1'b0, 16'h1300);
    idle();
    press(4'd0); press(4'd9); press(4'd5); press(4'd9);
    commit(1'b1, 1'b1, 16'h0959);
    idle();

    // Asynchronous reset during an entry.
    press(4'd5);
    chk("entry_before_reset", {15'd0, show, buf_now}, {15'd0, 1'b1, 16'h0005});
    #2 rst_n = 1'b0;
    #1;
    chk("reset_in_entry", {11'd0, show, lc, la, err, am_out, buf_now}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset during LOAD_TIME kills the strobe at once.
    press(4'd1); press(4'd0); press(4'd3); press(4'd0);
    am_sel = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("load_before_reset", {30'd0, lc, am_out}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("reset_in_load", {11'd0, show, lc, la, err, am_out, buf_now}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    idle();
    idle();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
Keypad-entry sequencer for the alarm clock.
- Collects up to four BCD digits from the keypad into a shift buffer.
- On the time button, pulses load_new_c to the time-counting block; on the alarm button, pulses load_new_a to the alarm register.
- Presents the buffer as the new_current_time_*/new_alarm_* value bus.
- Aborts the entry after an idle timeout.

Parameters:
TIMEOUT_SECS, 10, number of one_second pulses without a key before the entry is abandoned (1..255)

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
one_second  in  1  one-cycle timebase strobe, once per second
key  in  4  BCD digit from keypad, 0..9; 10..15 invalid
key_valid  in  1  one-cycle strobe qualifying key
time_button  in  1  one-cycle strobe: commit buffer as current time
alarm_button  in  1  one-cycle strobe: commit buffer as alarm time
am_sel  in  1  AM flag sampled at commit
key_buffer_ms_hr  out  4  buffer digit 3 (drives new_current_time_ms_hr and new_alarm_ms_hr)
key_buffer_ls_hr  out  4  buffer digit 2
key_buffer_ms_min  out  4  buffer digit 1
key_buffer_ls_min  out  4  buffer digit 0
key_buffer_AM  out  1  registered am_sel captured at commit
load_new_c  out  1  one-cycle load strobe to time counter
load_new_a  out  1  one-cycle load strobe to alarm register
show_new_time  out  1  display mux select: 1 while entry is in progress
entry_error  out  1  one-cycle strobe on rejected commit (VALIDATE_EN only)

Behaviour:
- Reset (reset=0, async): state IDLE; all buffer digits 0; key_buffer_AM 0; all strobes 0; show_new_time 0; digit count 0; timer 0.
- States: IDLE, ENTRY (1..3 digits held), STORED (4 digits held), LOAD_TIME, LOAD_ALARM.
- Key acceptance: key_valid=1 with key<=9.
  - Keys with key>9 are ignored and do not restart the timer.
- Shift rule: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key.
- IDLE + accepted key:
  - Buffer cleared, then key shifted in; result is 0,0,0,key.
  - Count=1; -> ENTRY.
- ENTRY + accepted key:
  - Shift; count++.
  - -> STORED when count reaches 4.
- STORED + key: ignored, no shift, but the timer restarts.
- ENTRY/STORED + time_button:
  - -> LOAD_TIME.
  - key_buffer_AM<=am_sel on the same edge.
  - A partial entry stays left-zero-padded.
- ENTRY/STORED + alarm_button: -> LOAD_ALARM, with the same AM capture.
- IDLE + any button: ignored.
- LOAD_TIME: load_new_c=1 for exactly this cycle; -> IDLE next edge. The buffer holds its value through LOAD_TIME.
- LOAD_ALARM: load_new_a=1 for exactly this cycle; -> IDLE next edge.
- Latency: button at edge N gives a strobe during cycle N+1.
- Strobes are registered (decoded from state register); no combinational path from inputs.
- show_new_time = 1 in ENTRY/STORED, 0 otherwise.
- Timer, ENTRY/STORED only:
  - Increments on one_second.
  - Clears on each accepted key and on leaving these states.
  - When a one_second would bring it to TIMEOUT_SECS: -> IDLE, buffer cleared, no strobe.
- Simultaneous events:
  - Button and key_valid in the same cycle: button wins, key dropped.
  - time_button and alarm_button together: time wins.
  - Button and timeout in the same cycle: button wins.
- Buttons/keys during LOAD_* are ignored.
- Reset mid-LOAD_*: strobe drops immediately (async); the load is not guaranteed.

Optional Feature:
Macro: TIME_SET_VALIDATE_EN.
- Defined: on commit, check the buffer as a 12-hour time.
  - ms_hr<=1.
  - Hour (ms_hr*10+ls_hr) in 1..12.
  - ms_min<=5; ls_min<=9 is guaranteed by key filtering.
  - Fail: no LOAD_*; entry_error=1 during cycle N+1; buffer cleared; -> IDLE.
- Undefined: no check; entry_error tied to 0.

Decomposition:
- Package clock_pkg:
  - DIGIT_W=4, MAX_DIGITS=4.
  - State typedef tsc_state_t {IDLE, ENTRY, STORED, LOAD_TIME, LOAD_ALARM}.
  - Constant MAX_HOUR=12.
- One sub-module: key_shift_buffer.
  - 4x4-bit shift register with clear, shift_en and digit count output.
  - FSM and timer stay in the top level.

Test Plan:
- Keys 1,2,5,8 then time_button (am_sel=1):
  - Buffer 1,2:5,8 after the 4th key; show_new_time=1.
  - load_new_c=1 for exactly one cycle; key_buffer_AM=1; then IDLE, show_new_time=0.
- Keys 7,3 then alarm_button:
  - Buffer 0,0:7,3; load_new_a single pulse; load_new_c stays 0.
- Keys 1,2,3,4,9 then time_button:
  - Fifth key ignored; buffer 1,2:3,4 loaded.
- Key 4, then TIMEOUT_SECS one_second pulses with no key:
  - Returns to IDLE, buffer 0, no strobe.
  - Repeat with key 15 injected mid-wait: still times out.
- Key 1 then time_button and alarm_button in the same cycle, also carrying key_valid:
  - Only load_new_c pulses; buffer 0,0:0,1.
- Reset low during ENTRY and during LOAD_TIME: all outputs 0 immediately.
- VALIDATE_EN: keys 1,3,0,0 then time_button -> entry_error pulse, no load_new_c. Keys 0,9,5,9 -> load_new_c.
